// File: rtl/camera_bus_bridge.sv
// Avalon-MM slave to camera register conduit: registers each host command and replays it on the export bus.
// Optional macro CAM_BRIDGE_TIMEOUT_EN adds an export wait-state timeout and the avs_s1_timeout pulse.
module camera_bus_bridge #(
  parameter int                ADDR_W      = 2,
  parameter int                DATA_W      = 32,
  parameter int                READ_LAT    = 0,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                avs_s1_clk,
  input  logic                avs_s1_reset_n,
  input  logic [ADDR_W-1:0]   avs_s1_address,
  input  logic                avs_s1_read,
  input  logic                avs_s1_write,
  input  logic [DATA_W-1:0]   avs_s1_writedata,
  input  logic [DATA_W/8-1:0] avs_s1_byteenable,
  output logic [DATA_W-1:0]   avs_s1_readdata,
  output logic                avs_s1_waitrequest,
  output logic                avs_s1_export_clk,
  output logic                avs_s1_export_reset,
  output logic [ADDR_W-1:0]   avs_s1_export_address,
  output logic                avs_s1_export_read,
  output logic                avs_s1_export_write,
  output logic [DATA_W-1:0]   avs_s1_export_writedata,
  output logic [DATA_W/8-1:0] avs_s1_export_byteenable,
  input  logic [DATA_W-1:0]   avs_s1_export_readdata,
  input  logic                avs_s1_export_waitrequest
`ifdef CAM_BRIDGE_TIMEOUT_EN
  ,
  output logic                avs_s1_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAT, DONE} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       rst_sync_p0;
  logic       rst_sync_p1;

`ifdef CAM_BRIDGE_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign avs_s1_export_clk   = avs_s1_clk;
  assign avs_s1_export_reset = rst_sync_p1;

  // camera reset: asserts with reset_n, releases two edges later
  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= 1'b1;
    end else begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      state                    <= IDLE;
      avs_s1_waitrequest       <= 1'b1;
      avs_s1_readdata          <= '0;
      avs_s1_export_address    <= '0;
      avs_s1_export_read       <= 1'b0;
      avs_s1_export_write      <= 1'b0;
      avs_s1_export_writedata  <= '0;
      avs_s1_export_byteenable <= '0;
      lat_cnt                  <= '0;
`ifdef CAM_BRIDGE_TIMEOUT_EN
      to_cnt                   <= '0;
      avs_s1_timeout           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          avs_s1_waitrequest <= 1'b1;
`ifdef CAM_BRIDGE_TIMEOUT_EN
          to_cnt             <= '0;
`endif
          if (avs_s1_read || avs_s1_write) begin
            avs_s1_export_address    <= avs_s1_address;
            avs_s1_export_writedata  <= avs_s1_writedata;
            avs_s1_export_byteenable <= avs_s1_byteenable;
            // a simultaneous read and write is issued as the write alone
            avs_s1_export_write      <= avs_s1_write;
            avs_s1_export_read       <= avs_s1_read & ~avs_s1_write;
            state                    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avs_s1_export_waitrequest) begin
            avs_s1_export_read  <= 1'b0;
            avs_s1_export_write <= 1'b0;
            if (avs_s1_export_write) begin
              avs_s1_waitrequest <= 1'b0;
              state              <= DONE;
            end else if (READ_LAT == 0) begin
              avs_s1_readdata    <= avs_s1_export_readdata;
              avs_s1_waitrequest <= 1'b0;
              state              <= DONE;
            end else begin
              lat_cnt <= 4'(READ_LAT - 1);
              state   <= LAT;
            end
          end
`ifdef CAM_BRIDGE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            avs_s1_export_read  <= 1'b0;
            avs_s1_export_write <= 1'b0;
            if (avs_s1_export_read) begin
              avs_s1_readdata <= ERR_DATA;
            end
            avs_s1_timeout     <= 1'b1;
            avs_s1_waitrequest <= 1'b0;
            state              <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        LAT: begin
          if (lat_cnt == 4'd0) begin
            avs_s1_readdata    <= avs_s1_export_readdata;
            avs_s1_waitrequest <= 1'b0;
            state              <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          avs_s1_waitrequest <= 1'b1;
`ifdef CAM_BRIDGE_TIMEOUT_EN
          avs_s1_timeout     <= 1'b0;
`endif
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_bus_bridge.sv
// Self-checking bench for camera_bus_bridge: vector table, directed corner cases and random traffic vs a transaction-level model.
`timescale 1ns/1ps
module tb_camera_bus_bridge;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int RL     = 3;
  localparam int TO_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] address;
  logic              read, write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              waitreq;
  logic              e_clk, e_reset;
  logic [ADDR_W-1:0] e_addr;
  logic              e_read, e_write;
  logic [DATA_W-1:0] e_wdata;
  logic [BE_W-1:0]   e_be;
  logic [DATA_W-1:0] erdata;
  logic              ewait;
`ifdef CAM_BRIDGE_TIMEOUT_EN
  logic              timeout;
`endif

  always #5 clk = ~clk;

  camera_bus_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(RL),
    .TIMEOUT_CYC(TO_CYC), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .avs_s1_clk(clk),
    .avs_s1_reset_n(rst_n),
    .avs_s1_address(address),
    .avs_s1_read(read),
    .avs_s1_write(write),
    .avs_s1_writedata(writedata),
    .avs_s1_byteenable(byteenable),
    .avs_s1_readdata(readdata),
    .avs_s1_waitrequest(waitreq),
    .avs_s1_export_clk(e_clk),
    .avs_s1_export_reset(e_reset),
    .avs_s1_export_address(e_addr),
    .avs_s1_export_read(e_read),
    .avs_s1_export_write(e_write),
    .avs_s1_export_writedata(e_wdata),
    .avs_s1_export_byteenable(e_be),
    .avs_s1_export_readdata(erdata),
    .avs_s1_export_waitrequest(ewait)
`ifdef CAM_BRIDGE_TIMEOUT_EN
    ,
    .avs_s1_timeout(timeout)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // cycle k spans posedge k .. posedge k+1
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // camera model: stalls each strobe stall_cfg cycles, logs accepts, returns rd_val RL cycles after accept
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [BE_W-1:0]   be;
  } acc_t;
  acc_t              acc_q[$];
  int                stall_cfg  = 0;
  int                stall_left = 0;
  int                strobe_cyc = 0;
  int                acc_cyc    = -100;
  bit                in_req     = 1'b0;
  logic [DATA_W-1:0] rd_val     = '0;

  initial begin
    ewait  = 1'b1;
    erdata = '0;
    forever begin
      @(negedge clk);
      if (!(e_read === 1'b1 || e_write === 1'b1)) begin
        in_req = 1'b0;
        ewait  = 1'($urandom_range(0, 1));
      end else begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cfg;
        end
        strobe_cyc++;
        if (stall_left > 0) begin
          ewait = 1'b1;
          stall_left--;
        end else begin
          ewait   = 1'b0;
          in_req  = 1'b0;
          acc_cyc = cyc;
          acc_q.push_back('{e_write, e_addr, e_wdata, e_be});
        end
      end
      erdata = (cyc == acc_cyc + RL) ? rd_val : $urandom;
    end
  end

  // one host transaction; returns at negedge+1 two cycles after completion
  task automatic host_txn(input string nm, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be, input int stall,
                          input logic [DATA_W-1:0] rv, input int exp_lat, input logic [DATA_W-1:0] exp_rd,
                          input int drop_after);
    int t0;
    int lat;
    logic [DATA_W-1:0] got;
    acc_q.delete();
    strobe_cyc = 0;
    stall_cfg  = stall;
    rd_val     = rv;
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    t0  = cyc;
    lat = -1;
    got = 'x;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (drop_after > 0 && cyc - t0 == drop_after) begin
        read = 1'b0; write = 1'b0;
      end
      if (waitreq === 1'b0) begin
        lat = cyc - t0;
        got = readdata;
        break;
      end
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " readdata"}, got, exp_rd);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check({nm, " waitreq back high"}, 32'(waitreq), 32'd1);
    @(negedge clk);
    #1;
    check({nm, " accept count"}, acc_q.size(), 1);
    check({nm, " strobe cycles"}, strobe_cyc, stall + 1);
    if (acc_q.size() > 0) begin
      check({nm, " export kind"}, 32'(acc_q[0].wr), 32'(wr));
      check({nm, " export addr"}, 32'(acc_q[0].a), 32'(a));
      check({nm, " export data"}, acc_q[0].d, d);
      check({nm, " export be"}, 32'(acc_q[0].be), 32'(be));
    end
  endtask

  typedef struct {
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [BE_W-1:0]   be;
    int                stall;
    logic [DATA_W-1:0] rv;
    int                exp_lat;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;
  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] model_rd;
    int lows;

    vt[0] = '{1'b0, 1'b1, 2'd2, 32'h12345678, 4'hF, 0, 32'h55555555, 2, 32'h00000000};
    vt[1] = '{1'b1, 1'b0, 2'd1, 32'h00000000, 4'hF, 0, 32'hCAFEF00D, 5, 32'hCAFEF00D};
    vt[2] = '{1'b0, 1'b1, 2'd3, 32'hA5A5A5A5, 4'h3, 4, 32'h00000000, 6, 32'hCAFEF00D};
    vt[3] = '{1'b1, 1'b1, 2'd0, 32'h11112222, 4'hC, 0, 32'h99999999, 2, 32'hCAFEF00D};
    vt[4] = '{1'b1, 1'b0, 2'd2, 32'h00000000, 4'h6, 2, 32'h0BADF00D, 7, 32'h0BADF00D};
    vt[5] = '{1'b0, 1'b1, 2'd1, 32'h00000000, 4'h0, 1, 32'h00000000, 3, 32'h0BADF00D};

    read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset waitreq", 32'(waitreq), 32'd1);
    check("reset export_read", 32'(e_read), 32'd0);
    check("reset export_write", 32'(e_write), 32'd0);
    check("reset export_reset", 32'(e_reset), 32'd1);
    check("reset readdata", readdata, 32'd0);
    check("reset export addr", 32'(e_addr), 32'd0);
    check("reset export wdata", e_wdata, 32'd0);
    check("reset export be", 32'(e_be), 32'd0);
    check("export clk follows clk", 32'(e_clk), 32'(clk));
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("export_reset after 1st edge", 32'(e_reset), 32'd1);
    @(posedge clk);
    #1 check("export_reset after 2nd edge", 32'(e_reset), 32'd0);
    @(negedge clk);
    #1;

    foreach (vt[i])
      host_txn($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].be,
               vt[i].stall, vt[i].rv, vt[i].exp_lat, vt[i].exp_rd, 0);

    // host abandons its read strobe one cycle in; the bridge must still finish it
    host_txn("drop", 1'b1, 1'b0, 2'd1, 32'h0, 4'hF, 3, 32'h13572468, 2 + 3 + RL, 32'h13572468, 1);

    // reset during ISSUE abandons the transaction
    acc_q.delete();
    stall_cfg = 100000;
    write = 1'b1; address = 2'd3; writedata = 32'hFEEDFACE; byteenable = 4'hF;
    @(posedge clk);
    #1 write = 1'b0;
    @(negedge clk);
    check("midreset strobe before", 32'(e_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset strobe async drop", 32'(e_write), 32'd0);
    check("midreset waitreq", 32'(waitreq), 32'd1);
    check("midreset export_reset", 32'(e_reset), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (waitreq !== 1'b1) lows++;
    end
    check("midreset no done cycle", lows, 0);
    check("midreset no accept", acc_q.size(), 0);
    #1;

    // random traffic against a transaction-level model
    model_rd = '0;
    for (int n = 0; n < 30; n++) begin
      int kind;
      int st;
      bit rd, wr;
      logic [DATA_W-1:0] rv;
      kind = $urandom_range(0, 2);
      st   = $urandom_range(0, 3);
      rd   = (kind != 1);
      wr   = (kind != 0);
      rv   = $urandom;
      if (rd && !wr) model_rd = rv;
      host_txn($sformatf("rand%0d", n), rd, wr, 2'($urandom), $urandom, 4'($urandom), st, rv,
               2 + st + ((rd && !wr) ? RL : 0), model_rd, 0);
    end

`ifdef CAM_BRIDGE_TIMEOUT_EN
    begin
      int t0;
      int lat;
      int pulses;
      logic [DATA_W-1:0] got;
      acc_q.delete();
      strobe_cyc = 0;
      stall_cfg  = 100000;
      read = 1'b1; address = 2'd1;
      t0 = cyc; lat = -1; pulses = 0; got = '0;
      @(posedge clk);
      #1 read = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (timeout === 1'b1) pulses++;
        if (waitreq === 1'b0 && lat < 0) begin
          lat = cyc - t0;
          got = readdata;
          check("timeout pulse with done", 32'(timeout), 32'd1);
        end
      end
      check("timeout latency", lat, 1 + TO_CYC);
      check("timeout strobe cycles", strobe_cyc, TO_CYC);
      check("timeout readdata", got, 32'hDEADBEEF);
      check("timeout pulse count", pulses, 1);
      check("timeout no accept", acc_q.size(), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
